// File: rtl/reg_wr_arb.sv
// Write-port arbiter for the 8x16 register file: two per-source FIFOs drained
// one write per cycle under round-robin, plus a pending-write scoreboard.

module reg_wr_arb_fifo #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [2:0]  push_adr,
    input  logic [15:0] push_data,
    output logic        ready,
    output logic        head_valid,
    output logic [2:0]  head_adr,
    output logic [15:0] head_data,
    output logic [7:0]  pending
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_adr  [DEPTH];
    logic [15:0]   r_data [DEPTH];
    logic [CW-1:0] w_wr_idx;
    logic [7:0]    w_pending;

    function automatic logic [7:0] onehot8(input logic [2:0] adr);
        onehot8 = 8'h01 << adr;
    endfunction

    // A pushed entry lands behind whatever survives this edge's pop.
    assign w_wr_idx   = r_cnt - {{(CW-1){1'b0}}, pop};
    assign ready      = (r_cnt != CW'(DEPTH));
    assign head_valid = (r_cnt != {CW{1'b0}});
    assign head_adr   = r_adr[0];
    assign head_data  = r_data[0];
    assign pending    = w_pending;

    // Entry storage: shift toward the head on pop, load at the tail on push.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_adr[i]  <= 3'd0;
                r_data[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (w_wr_idx == CW'(i))) begin
                    r_adr[i]  <= push_adr;
                    r_data[i] <= push_data;
                end else if (pop && (i < DEPTH - 1)) begin
                    r_adr[i]  <= r_adr[i+1];
                    r_data[i] <= r_data[i+1];
                end else begin
                    r_adr[i]  <= r_adr[i];
                    r_data[i] <= r_data[i];
                end
            end
        end
    end

    // Occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= {CW{1'b0}};
        end else begin
            case ({push, pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Scoreboard contribution: one-hot of every occupied slot.
    always_comb begin
        w_pending = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < r_cnt) begin
                w_pending = w_pending | onehot8(r_adr[i]);
            end else begin
                w_pending = w_pending;
            end
        end
    end
endmodule

module reg_wr_arb #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [2:0]  a_adr,
    input  logic [15:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [2:0]  b_adr,
    input  logic [15:0] b_data,
    output logic        b_ready,
    output logic        we,
    output logic [2:0]  W_adr,
    output logic [15:0] W,
    input  logic [2:0]  R_adr,
    input  logic [2:0]  S_adr,
    output logic [7:0]  pending,
    output logic        r_hazard,
    output logic        s_hazard,
    output logic        grant_b
);
    typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;

    src_e        r_last_grant;
    logic        w_ha;
    logic        w_hb;
    logic        w_grant_b;
    logic        w_push_a;
    logic        w_push_b;
    logic        w_pop_a;
    logic        w_pop_b;
    logic [2:0]  w_a_head_adr;
    logic [2:0]  w_b_head_adr;
    logic [15:0] w_a_head_data;
    logic [15:0] w_b_head_data;
    logic [7:0]  w_a_pending;
    logic [7:0]  w_b_pending;

    assign w_push_a = a_valid & a_ready;
    assign w_push_b = b_valid & b_ready;
    assign w_pop_a  = w_ha & ~w_grant_b;
    assign w_pop_b  = w_grant_b;

    reg_wr_arb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk        (clk),
        .reset      (reset),
        .push       (w_push_a),
        .pop        (w_pop_a),
        .push_adr   (a_adr),
        .push_data  (a_data),
        .ready      (a_ready),
        .head_valid (w_ha),
        .head_adr   (w_a_head_adr),
        .head_data  (w_a_head_data),
        .pending    (w_a_pending)
    );

    reg_wr_arb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk        (clk),
        .reset      (reset),
        .push       (w_push_b),
        .pop        (w_pop_b),
        .push_adr   (b_adr),
        .push_data  (b_data),
        .ready      (b_ready),
        .head_valid (w_hb),
        .head_adr   (w_b_head_adr),
        .head_data  (w_b_head_data),
        .pending    (w_b_pending)
    );

    // Round-robin: a contested cycle goes to the source that did not win last.
    always_comb begin
        w_grant_b = 1'b0;
        if (w_ha && w_hb) begin
            w_grant_b = (r_last_grant == SRC_A);
        end else if (w_hb) begin
            w_grant_b = 1'b1;
        end else begin
            w_grant_b = 1'b0;
        end
    end

    // Write-port mux; idle port drives zeros.
    always_comb begin
        we    = w_ha | w_hb;
        W_adr = 3'd0;
        W     = 16'd0;
        if (w_grant_b) begin
            W_adr = w_b_head_adr;
            W     = w_b_head_data;
        end else if (w_ha) begin
            W_adr = w_a_head_adr;
            W     = w_a_head_data;
        end else begin
            W_adr = 3'd0;
            W     = 16'd0;
        end
    end

    // Last-grant tracker; reset to B so A wins the first contest.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= SRC_B;
        end else if (we) begin
            r_last_grant <= w_grant_b ? SRC_B : SRC_A;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

    assign grant_b  = w_grant_b;
    assign pending  = w_a_pending | w_b_pending;
    assign r_hazard = pending[R_adr];
    assign s_hazard = pending[S_adr];
endmodule

// File: tb/tb_reg_wr_arb.sv
// Scoreboard bench for reg_wr_arb: stimulus queues expected writes, a negedge
// monitor pops and compares whenever we is asserted.

module tb_reg_wr_arb;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0;
    logic [2:0]  a_adr = 3'd0;
    logic [15:0] a_data = 16'd0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [2:0]  b_adr = 3'd0;
    logic [15:0] b_data = 16'd0;
    logic        b_ready;
    logic        we;
    logic [2:0]  W_adr;
    logic [15:0] W;
    logic [2:0]  R_adr = 3'd0;
    logic [2:0]  S_adr = 3'd0;
    logic [7:0]  pending;
    logic        r_hazard;
    logic        s_hazard;
    logic        grant_b;

    typedef struct packed {
        logic        src;
        logic [2:0]  adr;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] rf [8] = '{default: 16'h0000};
    int          n_total = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    reg_wr_arb #(.DEPTH(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .a_valid  (a_valid),
        .a_adr    (a_adr),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_adr    (b_adr),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .we       (we),
        .W_adr    (W_adr),
        .W        (W),
        .R_adr    (R_adr),
        .S_adr    (S_adr),
        .pending  (pending),
        .r_hazard (r_hazard),
        .s_hazard (s_hazard),
        .grant_b  (grant_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Register-file model loaded by the DUT write port.
    always @(posedge clk) begin
        if (!reset && we) rf[W_adr] <= W;
    end

    // Monitor: every write must match the next expected entry.
    always @(negedge clk) begin
        if (!reset && we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(we), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_adr", 32'(W_adr), 32'(mon_e.adr));
                chk("wr_data", 32'(W), 32'(mon_e.data));
                chk("wr_src", 32'(grant_b), 32'(mon_e.src));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("drain_done", 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    task automatic push_exp(input logic src, input logic [2:0] adr, input logic [15:0] data);
        exp_t e;
        e.src = src;
        e.adr = adr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  ra_exp;
        logic [7:0]  rb_exp;
        logic        acc_a;
        logic        acc_b;
        int          ia;
        int          ib;
        logic [15:0] snap1;
        logic [15:0] snap4;
        logic [15:0] snap5;

        tick();
        tick();
        reset = 1'b0;

        // Reset state, then single write to r3.
        @(negedge clk);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_W_adr", 32'(W_adr), 32'd0);
        chk("rst_W", 32'(W), 32'd0);
        chk("rst_pending", 32'(pending), 32'h00);
        chk("rst_r_hazard", 32'(r_hazard), 32'd0);
        chk("rst_s_hazard", 32'(s_hazard), 32'd0);
        chk("rst_grant_b", 32'(grant_b), 32'd0);
        chk("rst_a_ready", 32'(a_ready), 32'd1);
        chk("rst_b_ready", 32'(b_ready), 32'd1);
        a_valid = 1'b1; a_adr = 3'd3; a_data = 16'h1234;
        push_exp(1'b0, 3'd3, 16'h1234);
        tick();
        a_valid = 1'b0;
        @(negedge clk);
        chk("t1_we", 32'(we), 32'd1);
        chk("t1_pending", 32'(pending), 32'h08);
        tick();
        @(negedge clk);
        chk("t1_pending_clr", 32'(pending), 32'h00);
        chk("t1_we_idle", 32'(we), 32'd0);
        chk("t1_rf3", 32'(rf[3]), 32'h1234);

        // Simultaneous push: A wins first after reset.
        do_reset();
        a_valid = 1'b1; a_adr = 3'd1; a_data = 16'hAAAA;
        b_valid = 1'b1; b_adr = 3'd2; b_data = 16'h5555;
        push_exp(1'b0, 3'd1, 16'hAAAA);
        push_exp(1'b1, 3'd2, 16'h5555);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        chk("t2_pending", 32'(pending), 32'h06);
        chk("t2_grant_b_c1", 32'(grant_b), 32'd0);
        tick();
        @(negedge clk);
        chk("t2_grant_b_c2", 32'(grant_b), 32'd1);
        drain();

        // Sustained dual-source traffic: alternating grants, back-pressure.
        do_reset();
        ra_exp = 8'h57;
        rb_exp = 8'hAB;
        for (int i = 0; i < 5; i++) begin
            push_exp(1'b0, 3'(i), 16'hA000 + 16'(i));
            push_exp(1'b1, 3'(7 - i), 16'hB000 + 16'(i));
        end
        ia = 0;
        ib = 0;
        for (int c = 0; c < 8; c++) begin
            a_valid = 1'b1; a_adr = 3'(ia); a_data = 16'hA000 + 16'(ia);
            b_valid = 1'b1; b_adr = 3'(7 - ib); b_data = 16'hB000 + 16'(ib);
            @(negedge clk);
            chk("sat_a_ready", 32'(a_ready), 32'(ra_exp[c]));
            chk("sat_b_ready", 32'(b_ready), 32'(rb_exp[c]));
            acc_a = a_ready;
            acc_b = b_ready;
            tick();
            if (acc_a) ia++;
            if (acc_b) ib++;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        chk("sat_a_accepted", 32'(ia), 32'd5);
        chk("sat_b_accepted", 32'(ib), 32'd5);
        drain();

        // Read hazards on a queued register.
        do_reset();
        R_adr = 3'd5; S_adr = 3'd6;
        a_valid = 1'b1; a_adr = 3'd5; a_data = 16'h5A5A;
        push_exp(1'b0, 3'd5, 16'h5A5A);
        tick();
        a_data = 16'h5A5B;
        push_exp(1'b0, 3'd5, 16'h5A5B);
        @(negedge clk);
        chk("hz_r_c1", 32'(r_hazard), 32'd1);
        chk("hz_s_c1", 32'(s_hazard), 32'd0);
        tick();
        a_valid = 1'b0;
        @(negedge clk);
        chk("hz_r_c2", 32'(r_hazard), 32'd1);
        chk("hz_s_c2", 32'(s_hazard), 32'd0);
        S_adr = 3'd5;
        #1;
        chk("hz_s_same", 32'(s_hazard), 32'd1);
        S_adr = 3'd6;
        tick();
        @(negedge clk);
        chk("hz_r_clr", 32'(r_hazard), 32'd0);
        chk("hz_s_clr", 32'(s_hazard), 32'd0);
        chk("hz_rf5", 32'(rf[5]), 32'h5A5B);

        // Reset with entries queued: queued writes are dropped.
        do_reset();
        snap1 = rf[1];
        snap4 = rf[4];
        snap5 = rf[5];
        a_valid = 1'b1; a_adr = 3'd0; a_data = 16'hD000;
        b_valid = 1'b1; b_adr = 3'd4; b_data = 16'hE000;
        push_exp(1'b0, 3'd0, 16'hD000);
        tick();
        a_adr = 3'd1; a_data = 16'hD001;
        b_adr = 3'd5; b_data = 16'hE001;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("mr_pending_full", 32'(pending), 32'h32);
        chk("mr_a_ready_full", 32'(a_ready), 32'd1);
        chk("mr_b_ready_full", 32'(b_ready), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("mr_we", 32'(we), 32'd0);
        chk("mr_W_adr", 32'(W_adr), 32'd0);
        chk("mr_W", 32'(W), 32'd0);
        chk("mr_grant_b", 32'(grant_b), 32'd0);
        chk("mr_pending", 32'(pending), 32'h00);
        chk("mr_a_ready", 32'(a_ready), 32'd1);
        chk("mr_b_ready", 32'(b_ready), 32'd1);
        repeat (3) tick();
        chk("mr_rf0", 32'(rf[0]), 32'hD000);
        chk("mr_rf1", 32'(rf[1]), 32'(snap1));
        chk("mr_rf4", 32'(rf[4]), 32'(snap4));
        chk("mr_rf5", 32'(rf[5]), 32'(snap5));

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
